// File: rtl/miner_dispatch.sv
// miner_dispatch: splits a job's nonce range across 2^LOG2_CORES miner cores,
// starts them, tracks completion, and funnels golden nonces through a
// round-robin arbiter into a small result FIFO for the UART transmitter.
module miner_dispatch #(
  parameter int LOG2_CORES      = 2,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                            hash_clk,
  input  logic                            reset_n,
  input  logic                            new_work,
  input  logic [31:0]                     nonce_min,
  input  logic [31:0]                     nonce_max,
  output logic [(1<<LOG2_CORES)-1:0]      core_start,
  output logic [32*(1<<LOG2_CORES)-1:0]   core_nonce_min,
  output logic [32*(1<<LOG2_CORES)-1:0]   core_nonce_max,
  input  logic [(1<<LOG2_CORES)-1:0]      core_done,
  input  logic [(1<<LOG2_CORES)-1:0]      core_found,
  input  logic [32*(1<<LOG2_CORES)-1:0]   core_nonce,
  output logic                            golden_valid,
  output logic [31:0]                     golden_nonce,
  input  logic                            golden_ready,
  output logic                            job_busy,
  output logic                            job_done,
  output logic                            overflow
);

  localparam int N     = 1 << LOG2_CORES;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int IDXW  = (LOG2_CORES > 0) ? LOG2_CORES : 1;
  localparam int AW    = (FIFO_DEPTH_LOG2 > 0) ? FIFO_DEPTH_LOG2 : 1;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic [31:0]         min_r;
  logic [31:0]         max_r;
  logic [N-1:0]        active_r;
  logic [N-1:0]        core_start_r;
  logic [32*N-1:0]     core_nonce_min_r;
  logic [32*N-1:0]     core_nonce_max_r;
  logic                job_busy_r;
  logic                job_done_r;
  logic                overflow_r;

  logic [N-1:0]        pend_r;
  logic [31:0]         pend_nonce_r [N];
  logic [IDXW-1:0]     rr_ptr_r;

  logic [31:0]         fifo_mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic                golden_valid_r;

  logic                abort_s;
  logic                accept_s;
  logic [32:0]         slice_s;
  logic                slice_zero_s;
  logic                empty_job_s;
  logic [N-1:0]        load_mask_s;
  logic [31:0]         range_min_s [N];
  logic [31:0]         range_max_s [N];
  logic                fifo_full_s;
  logic                pop_s;
  logic                can_push_s;
  logic                grant_vld_s;
  logic [IDXW-1:0]     grant_idx_s;
  logic [IDXW-1:0]     grant_next_s;
  logic [IDXW-1:0]     idx_v;
  logic [N-1:0]        grant_mask_s;
  logic [N-1:0]        found_ok_s;
  logic                drop_any_s;
  logic [CW-1:0]       count_next_s;

  // A new job arriving while one is in flight aborts it and flushes results;
  // found pulses are only meaningful while a job is (or just was) running.
  assign abort_s      = new_work && (state_r != ST_IDLE);
  assign accept_s     = (state_r != ST_IDLE);
  assign found_ok_s   = core_found & {N{accept_s}};
  assign empty_job_s  = (max_r < min_r);
  assign slice_s      = ({1'b0, max_r} - {1'b0, min_r} + 33'd1) >> LOG2_CORES;
  assign slice_zero_s = (slice_s == 33'd0);
  assign fifo_full_s  = (count_r == CW'(DEPTH));
  assign pop_s        = golden_valid_r && golden_ready;
  assign can_push_s   = !fifo_full_s || pop_s;

  // Per-core slice bounds; last core absorbs the remainder, core 0 takes the
  // whole range when there are fewer nonces than cores.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      range_min_s[i] = min_r + (32'(slice_s) * 32'(i));
      if (i == N - 1) begin
        range_max_s[i] = max_r;
      end else if ((i == 0) && slice_zero_s) begin
        range_max_s[i] = max_r;
      end else begin
        range_max_s[i] = range_min_s[i] + 32'(slice_s) - 32'd1;
      end
    end
  end

  // Which cores take part in the job being loaded.
  always_comb begin
    load_mask_s = '0;
    if (empty_job_s) begin
      load_mask_s = '0;
    end else if (slice_zero_s) begin
      load_mask_s[0] = 1'b1;
    end else begin
      load_mask_s = '1;
    end
  end

  // Round-robin pick of one pending result, starting at the pointer.
  always_comb begin
    grant_vld_s  = 1'b0;
    grant_idx_s  = '0;
    grant_mask_s = '0;
    idx_v        = '0;
    if (can_push_s && !abort_s) begin
      for (int k = 0; k < N; k++) begin
        idx_v = rr_ptr_r + IDXW'(k);
        if (!grant_vld_s && pend_r[idx_v]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = idx_v;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      grant_vld_s = 1'b0;
    end
    grant_mask_s[grant_idx_s] = grant_vld_s;
    if (grant_idx_s == IDXW'(N - 1)) begin
      grant_next_s = '0;
    end else begin
      grant_next_s = grant_idx_s + IDXW'(1);
    end
  end

  // A found pulse is dropped only when its pend slot is occupied and not
  // being drained in the same cycle.
  assign drop_any_s = |(found_ok_s & pend_r & ~grant_mask_s);

  // Next FIFO occupancy; push-while-full-with-pop keeps the count.
  always_comb begin
    case ({grant_vld_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Job sequencer: latch, split, start, wait for completion, report.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      min_r            <= 32'd0;
      max_r            <= 32'd0;
      active_r         <= '0;
      core_start_r     <= '0;
      core_nonce_min_r <= '0;
      core_nonce_max_r <= '0;
      job_busy_r       <= 1'b0;
      job_done_r       <= 1'b0;
    end else if (new_work) begin
      min_r        <= nonce_min;
      max_r        <= nonce_max;
      state_r      <= ST_LOAD;
      job_busy_r   <= 1'b1;
      core_start_r <= '0;
      job_done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          core_start_r <= '0;
          job_done_r   <= 1'b0;
        end
        ST_LOAD: begin
          for (int i = 0; i < N; i++) begin
            core_nonce_min_r[32*i +: 32] <= range_min_s[i];
            core_nonce_max_r[32*i +: 32] <= range_max_s[i];
          end
          active_r <= load_mask_s;
          if (empty_job_s) begin
            state_r      <= ST_DONE;
            job_busy_r   <= 1'b0;
            job_done_r   <= 1'b1;
            core_start_r <= '0;
          end else begin
            state_r      <= ST_START;
            core_start_r <= load_mask_s;
          end
        end
        ST_START: begin
          core_start_r <= '0;
          state_r      <= ST_RUN;
        end
        ST_RUN: begin
          if ((core_done & active_r) == active_r) begin
            state_r    <= ST_DONE;
            job_busy_r <= 1'b0;
            job_done_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          job_done_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          job_busy_r   <= 1'b0;
          job_done_r   <= 1'b0;
          core_start_r <= '0;
        end
      endcase
    end
  end

  // Pending-result slots, arbiter pointer and sticky overflow flag.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r     <= '0;
      rr_ptr_r   <= '0;
      overflow_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        pend_nonce_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (abort_s) begin
          pend_r[i] <= 1'b0;
        end else if (found_ok_s[i] && (!pend_r[i] || grant_mask_s[i])) begin
          pend_r[i]       <= 1'b1;
          pend_nonce_r[i] <= core_nonce[32*i +: 32];
        end else if (grant_mask_s[i]) begin
          pend_r[i] <= 1'b0;
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
      if (grant_vld_s) begin
        rr_ptr_r <= grant_next_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (new_work) begin
        overflow_r <= 1'b0;
      end else if (drop_any_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Result FIFO; flushed when a running job is aborted.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      golden_valid_r <= 1'b0;
      for (int d = 0; d < DEPTH; d++) begin
        fifo_mem_r[d] <= 32'd0;
      end
    end else if (abort_s) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      golden_valid_r <= 1'b0;
    end else begin
      if (grant_vld_s) begin
        fifo_mem_r[wr_ptr_r] <= pend_nonce_r[grant_idx_s];
        wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? '0 : wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? '0 : rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r        <= count_next_s;
      golden_valid_r <= (count_next_s != CW'(0));
    end
  end

  assign core_start     = core_start_r;
  assign core_nonce_min = core_nonce_min_r;
  assign core_nonce_max = core_nonce_max_r;
  assign job_busy       = job_busy_r;
  assign job_done       = job_done_r;
  assign overflow       = overflow_r;
  assign golden_valid   = golden_valid_r;
  assign golden_nonce   = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_miner_dispatch.sv
// Self-checking bench for miner_dispatch (4 cores, 4-entry result FIFO).
module tb_miner_dispatch;

  logic          hash_clk = 1'b0;
  logic          reset_n;
  logic          new_work;
  logic [31:0]   nonce_min;
  logic [31:0]   nonce_max;
  logic [3:0]    core_start;
  logic [127:0]  core_nonce_min;
  logic [127:0]  core_nonce_max;
  logic [3:0]    core_done;
  logic [3:0]    core_found;
  logic [127:0]  core_nonce;
  logic          golden_valid;
  logic [31:0]   golden_nonce;
  logic          golden_ready;
  logic          job_busy;
  logic          job_done;
  logic          overflow;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [31:0]   sb_q [$];

  miner_dispatch #(.LOG2_CORES(2), .FIFO_DEPTH_LOG2(2)) dut (
    .hash_clk       (hash_clk),
    .reset_n        (reset_n),
    .new_work       (new_work),
    .nonce_min      (nonce_min),
    .nonce_max      (nonce_max),
    .core_start     (core_start),
    .core_nonce_min (core_nonce_min),
    .core_nonce_max (core_nonce_max),
    .core_done      (core_done),
    .core_found     (core_found),
    .core_nonce     (core_nonce),
    .golden_valid   (golden_valid),
    .golden_nonce   (golden_nonce),
    .golden_ready   (golden_ready),
    .job_busy       (job_busy),
    .job_done       (job_done),
    .overflow       (overflow)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic new_job(input logic [31:0] mn, input logic [31:0] mx);
    new_work  = 1'b1;
    nonce_min = mn;
    nonce_max = mx;
    tick();
    new_work  = 1'b0;
  endtask

  task automatic drain(input int budget);
    logic [31:0] exp_v;
    golden_ready = 1'b1;
    for (int c = 0; c < budget && sb_q.size() > 0; c++) begin
      if (golden_valid) begin
        exp_v = sb_q.pop_front();
        check_eq("golden_order", golden_nonce, exp_v);
      end
      tick();
    end
    golden_ready = 1'b0;
    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("fifo_empty_after_drain", golden_valid, 1'b0);
  endtask

  initial begin
    reset_n      = 1'b0;
    new_work     = 1'b0;
    nonce_min    = 32'd0;
    nonce_max    = 32'd0;
    core_done    = 4'd0;
    core_found   = 4'd0;
    core_nonce   = 128'd0;
    golden_ready = 1'b0;
    #12;
    check_eq("rst_core_start", core_start, 4'd0);
    check_eq("rst_busy", job_busy, 1'b0);
    check_eq("rst_done", job_done, 1'b0);
    check_eq("rst_valid", golden_valid, 1'b0);
    check_eq("rst_nonce", golden_nonce, 32'd0);
    check_eq("rst_min", core_nonce_min, 128'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // Even split of 0..FFFF across four cores.
    new_job(32'h0000_0000, 32'h0000_FFFF);
    check_eq("t1_busy_c1", job_busy, 1'b1);
    check_eq("t1_start_c1", core_start, 4'd0);
    tick();
    check_eq("t1_start_c2", core_start, 4'b1111);
    check_eq("t1_min", core_nonce_min, {32'h0000_C000, 32'h0000_8000, 32'h0000_4000, 32'h0000_0000});
    check_eq("t1_max", core_nonce_max, {32'h0000_FFFF, 32'h0000_BFFF, 32'h0000_7FFF, 32'h0000_3FFF});
    tick();
    check_eq("t1_start_c3", core_start, 4'd0);
    core_done = 4'b0111;
    tick();
    tick();
    check_eq("t1_partial_done", job_done, 1'b0);
    check_eq("t1_partial_busy", job_busy, 1'b1);
    core_done = 4'b1111;
    tick();
    check_eq("t1_done_pulse", job_done, 1'b1);
    check_eq("t1_busy_low", job_busy, 1'b0);
    tick();
    check_eq("t1_done_once", job_done, 1'b0);
    core_done = 4'd0;

    // Fewer nonces than cores: core 0 alone.
    new_job(32'd0, 32'd2);
    tick();
    check_eq("t2_start", core_start, 4'b0001);
    check_eq("t2_min0", core_nonce_min[31:0], 32'd0);
    check_eq("t2_max0", core_nonce_max[31:0], 32'd2);
    tick();
    core_done = 4'b1110;
    tick();
    tick();
    check_eq("t2_ignore_inactive", job_done, 1'b0);
    core_done = 4'b0001;
    tick();
    check_eq("t2_done", job_done, 1'b1);
    tick();
    core_done = 4'd0;

    // Top of the nonce space, no wrap.
    new_job(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    tick();
    check_eq("t3_min0", core_nonce_min[31:0], 32'hFFFF_FFF0);
    check_eq("t3_max0", core_nonce_max[31:0], 32'hFFFF_FFF3);
    check_eq("t3_min3", core_nonce_min[127:96], 32'hFFFF_FFFC);
    check_eq("t3_max3", core_nonce_max[127:96], 32'hFFFF_FFFF);
    tick();
    core_done = 4'b1111;
    tick();
    check_eq("t3_done", job_done, 1'b1);
    tick();
    core_done = 4'd0;

    // Empty job.
    new_job(32'd5, 32'd4);
    check_eq("t3e_busy_c1", job_busy, 1'b1);
    tick();
    check_eq("t3e_done_c2", job_done, 1'b1);
    check_eq("t3e_no_start", core_start, 4'd0);
    tick();
    check_eq("t3e_done_once", job_done, 1'b0);
    check_eq("t3e_idle_busy", job_busy, 1'b0);

    // Simultaneous finds on cores 0,1,3 collected in round-robin order.
    new_job(32'h0000_0000, 32'h0000_FFFF);
    tick();
    tick();
    core_nonce = {32'h0000_00A3, 32'hDEAD_BEEF, 32'h0000_00A1, 32'h0000_00A0};
    core_found = 4'b1011;
    sb_q.push_back(32'h0000_00A0);
    sb_q.push_back(32'h0000_00A1);
    sb_q.push_back(32'h0000_00A3);
    tick();
    core_found = 4'd0;
    check_eq("t4_valid_t1", golden_valid, 1'b0);
    tick();
    check_eq("t4_valid_t2", golden_valid, 1'b1);
    check_eq("t4_head_t2", golden_nonce, 32'h0000_00A0);
    tick();
    tick();
    check_eq("t4_no_ovf", overflow, 1'b0);
    drain(20);

    // Fill the FIFO, then hold one result in pend and drop a second one.
    core_nonce = {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
    core_found = 4'b1111;
    for (int i = 0; i < 4; i++) sb_q.push_back(32'h0000_00C0 + 32'(i));
    tick();
    core_found = 4'd0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t5_full_valid", golden_valid, 1'b1);
    check_eq("t5_full_head", golden_nonce, 32'h0000_00C0);
    core_nonce[95:64] = 32'h0000_00D2;
    core_found = 4'b0100;
    tick();
    core_found = 4'd0;
    tick();
    check_eq("t5_ovf_before_drop", overflow, 1'b0);
    core_nonce[95:64] = 32'h0000_00E2;
    core_found = 4'b0100;
    tick();
    core_found = 4'd0;
    check_eq("t5_ovf_set", overflow, 1'b1);
    check_eq("t5_head_stable", golden_nonce, 32'h0000_00C0);
    sb_q.push_back(32'h0000_00D2);
    drain(20);
    check_eq("t5_ovf_sticky", overflow, 1'b1);

    // Refill, leave a pend, then abort right as the old job completes.
    core_nonce = {32'h0000_00F3, 32'h0000_00F2, 32'h0000_00F1, 32'h0000_00F0};
    core_found = 4'b1111;
    tick();
    core_found = 4'd0;
    for (int i = 0; i < 5; i++) tick();
    core_nonce[95:64] = 32'h0000_0062;
    core_found = 4'b0100;
    tick();
    core_found = 4'd0;
    tick();
    core_done = 4'b1111;
    new_job(32'h0000_1000, 32'h0000_1FFF);
    core_done = 4'd0;
    check_eq("t6_no_done_c1", job_done, 1'b0);
    check_eq("t6_flush_valid", golden_valid, 1'b0);
    check_eq("t6_flush_ovf", overflow, 1'b0);
    check_eq("t6_busy_c1", job_busy, 1'b1);
    tick();
    check_eq("t6_no_done_c2", job_done, 1'b0);
    check_eq("t6_restart", core_start, 4'b1111);
    check_eq("t6_min", core_nonce_min, {32'h0000_1C00, 32'h0000_1800, 32'h0000_1400, 32'h0000_1000});
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_pend_cleared", golden_valid, 1'b0);
    end

    // Reset mid-RUN with a result queued.
    core_nonce[63:32] = 32'h0000_0071;
    core_found = 4'b0010;
    tick();
    core_found = 4'd0;
    tick();
    check_eq("t7_valid_pre", golden_valid, 1'b1);
    check_eq("t7_head_pre", golden_nonce, 32'h0000_0071);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t7_rst_busy", job_busy, 1'b0);
    check_eq("t7_rst_valid", golden_valid, 1'b0);
    check_eq("t7_rst_nonce", golden_nonce, 32'd0);
    check_eq("t7_rst_min", core_nonce_min, 128'd0);
    check_eq("t7_rst_max", core_nonce_max, 128'd0);
    check_eq("t7_rst_start", core_start, 4'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("t7_post_busy", job_busy, 1'b0);
    check_eq("t7_post_done", job_done, 1'b0);
    check_eq("t7_post_valid", golden_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
